spi_bus_arb: RTL

SPI_BUS_ARB -- requirements
Module: spi_bus_arb

---
 rtl/spi_bus_arb.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arb
// Purpose  : Round-robin arbiter that shares one SPI master between four
//            requesters. Each granted transaction drives a slave select and
//            a launch strobe, then waits for completion or a timeout. After
//            that it pauses for an inter-transaction gap.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arb #(
  parameter int GAP_CYC = 4,     // idle cycles between transactions (>= 1)
  parameter int TIMEOUT = 4096   // max cycles in BUSY (1..4096)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] cmd_in,
  input  logic [11:0] tgt_in,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [15:0] rsp,
  output logic        err,
  output logic        busy,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic [4:0]  ss_sel
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of a phase is at count N-1.
  localparam logic [11:0] c_TIMEOUT_LAST = 12'(TIMEOUT - 1);
  localparam logic [11:0] c_GAP_LAST     = 12'(GAP_CYC - 1);
  localparam logic [2:0]  c_TGT_MAX      = 3'd4;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [11:0] r_cnt;
  logic        r_tgt_bad;

  logic [3:0]  w_req_eff;
  logic        w_found;
  logic [1:0]  w_gidx;
  logic [2:0]  w_tgt;
  logic [15:0] w_cmd;
  logic        w_tgt_ok;

  logic        w_grant;
  logic        w_done_ok;
  logic        w_timeout;
  logic        w_bad_ack;

  // A requester whose ack is showing still has req high for this cycle.
  // An invalid-target ack lands while already back in IDLE. Masking here
  // stops that stale request from being granted a second time.
  assign w_req_eff = req & ~ack;

  assign busy = (r_state != S_IDLE);

  // Round-robin search starting at r_ptr, wrapping modulo 4.
  always_comb begin : p_arb
    logic [1:0] idx;
    w_found = 1'b0;
    w_gidx  = r_ptr;
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!w_found && w_req_eff[idx]) begin
        w_found = 1'b1;
        w_gidx  = idx;
      end
    end
  end

  // Select the command and target fields of the winning requester.
  always_comb begin
    w_tgt = tgt_in[2:0];
    w_cmd = cmd_in[15:0];
    for (int i = 0; i < 4; i++) begin
      if (w_gidx == 2'(i)) begin
        w_tgt = tgt_in[3*i +: 3];
        w_cmd = cmd_in[16*i +: 16];
      end
    end
  end

  assign w_tgt_ok = (w_tgt <= c_TGT_MAX);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and one-cycle control events.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    w_bad_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // An invalid target never reaches the SPI master. It is acked with
        // an error and the arbiter goes straight back to IDLE without a gap.
        if (r_tgt_bad) begin
          w_bad_ack   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // spi_done is checked first, so it wins over a timeout in the same cycle.
        if (spi_done) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_GAP;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Phase counter: cleared on every state change; counts in BUSY and GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 12'd0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= 12'd0;
    end else if (r_state == S_BUSY || r_state == S_GAP) begin
      r_cnt <= r_cnt + 12'd1;
    end
  end

  // Registered outputs: grant/select capture, launch strobe, and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 2'd0;
      r_tgt_bad <= 1'b0;
      gnt       <= 4'd0;
      ack       <= 4'd0;
      err       <= 1'b0;
      rsp       <= 16'd0;
      spi_cmd   <= 16'd0;
      spi_wrt   <= 1'b0;
      ss_sel    <= 5'd0;
    end else begin
      ack     <= 4'd0;
      err     <= 1'b0;
      // The strobe is registered off LAUNCH, so it follows the select by one cycle.
      spi_wrt <= (r_state == S_LAUNCH) && !r_tgt_bad;

      if (w_grant) begin
        gnt       <= 4'b0001 << w_gidx;
        spi_cmd   <= w_cmd;
        ss_sel    <= w_tgt_ok ? (5'b00001 << w_tgt) : 5'd0;
        r_tgt_bad <= !w_tgt_ok;
        r_ptr     <= w_gidx + 2'd1;
      end

      if (w_done_ok) begin
        ack    <= gnt;
        rsp    <= spi_rd;
        gnt    <= 4'd0;
        ss_sel <= 5'd0;
      end

      if (w_timeout || w_bad_ack) begin
        ack    <= gnt;
        err    <= 1'b1;
        rsp    <= 16'd0;
        gnt    <= 4'd0;
        ss_sel <= 5'd0;
      end
    end
  end

endmodule
`default_nettype wire
